bounce_sound: RTL and testbench



---
 rtl/bounce_sound_if.sv | 12 +
 rtl/bounce_sound.sv | 167 ++++++++++++++++
 tb/tb_bounce_sound.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bounce_sound_if.sv
// Event/tone signal bundle between a game controller (master) and the
// bounce_sound buzzer driver (slave).
interface bounce_sound_if;
  logic       mute;
  logic [1:0] bounce;
  logic       buzzer;
  logic       busy;
  logic [1:0] tone_id;

  modport master (output mute, output bounce, input buzzer, input busy, input tone_id);
  modport slave  (input mute, input bounce, output buzzer, output busy, output tone_id);
endinterface

// File: rtl/bounce_sound.sv
// Piezo tone generator for wall/paddle/score bounces: TONE then silent GAP.
// Optional one-deep pending slot enabled by defining BOUNCE_SOUND_QUEUE_EN.
module bounce_sound #(
  parameter int WALL_HALF   = 6000,
  parameter int PADDLE_HALF = 3000,
  parameter int SCORE_HALF  = 12000,
  parameter int TONE_CYCLES = 1200000,
  parameter int GAP_CYCLES  = 120000
) (
  input  logic          clk,
  input  logic          reset,
  bounce_sound_if.slave bus
);

  localparam int DUR_MAX  = (2 * TONE_CYCLES > GAP_CYCLES) ? 2 * TONE_CYCLES : GAP_CYCLES;
  localparam int DUR_W    = $clog2(DUR_MAX + 1);
  localparam int HALF_MX1 = (WALL_HALF > PADDLE_HALF) ? WALL_HALF : PADDLE_HALF;
  localparam int HALF_MAX = (HALF_MX1 > SCORE_HALF) ? HALF_MX1 : SCORE_HALF;
  localparam int HALF_W   = $clog2(HALF_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [HALF_W-1:0] half_of(input logic [1:0] code);
    case (code)
      2'd1:    half_of = HALF_W'(WALL_HALF - 1);
      2'd2:    half_of = HALF_W'(PADDLE_HALF - 1);
      2'd3:    half_of = HALF_W'(SCORE_HALF - 1);
      default: half_of = {HALF_W{1'b0}};
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] tone_len_of(input logic [1:0] code);
    case (code)
      2'd3:    tone_len_of = DUR_W'(2 * TONE_CYCLES - 1);
      default: tone_len_of = DUR_W'(TONE_CYCLES - 1);
    endcase
  endfunction

  state_t            state_q;
  logic [1:0]        bounce_q;
  logic [1:0]        tone_id_q;
  logic              busy_q;
  logic              buzzer_q;
  logic              phase_q;
  logic [HALF_W-1:0] half_q;
  logic [DUR_W-1:0]  dur_q;

  logic              event_s;
  logic [1:0]        start_code_d;
  logic              start_s;

`ifdef BOUNCE_SOUND_QUEUE_EN
  logic [1:0]        pend_q;
  logic              take_s;
  // Codes double as priorities, so an empty slot (0) loses to any event.
  always_comb begin
    take_s = event_s && (bus.bounce >= pend_q);
  end
`endif

  // Event detection and choice of the code that starts a tone this cycle.
  always_comb begin
    event_s      = (bus.bounce != 2'd0) && (bus.bounce != bounce_q);
    start_code_d = 2'd0;
    if (state_q == ST_IDLE) begin
      start_code_d = event_s ? bus.bounce : 2'd0;
    end else if ((state_q == ST_GAP) && (dur_q == {DUR_W{1'b0}})) begin
`ifdef BOUNCE_SOUND_QUEUE_EN
      start_code_d = take_s ? bus.bounce : pend_q;
`else
      start_code_d = 2'd0;
`endif
    end else begin
      start_code_d = 2'd0;
    end
    start_s = (start_code_d != 2'd0);
  end

  // Tone FSM; all outputs come straight from registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bounce_q  <= 2'd0;
      tone_id_q <= 2'd0;
      busy_q    <= 1'b0;
      buzzer_q  <= 1'b0;
      phase_q   <= 1'b0;
      half_q    <= {HALF_W{1'b0}};
      dur_q     <= {DUR_W{1'b0}};
`ifdef BOUNCE_SOUND_QUEUE_EN
      pend_q    <= 2'd0;
`endif
    end else begin
      bounce_q <= bus.bounce;
      if (start_s) begin
        state_q   <= ST_TONE;
        tone_id_q <= start_code_d;
        busy_q    <= 1'b1;
        phase_q   <= 1'b1;
        buzzer_q  <= ~bus.mute;
        half_q    <= half_of(start_code_d);
        dur_q     <= tone_len_of(start_code_d);
`ifdef BOUNCE_SOUND_QUEUE_EN
        pend_q    <= 2'd0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            buzzer_q <= 1'b0;
          end
          ST_TONE: begin
            // Phase keeps counting while muted so unmuting stays in step.
            if (half_q == {HALF_W{1'b0}}) begin
              phase_q  <= ~phase_q;
              half_q   <= half_of(tone_id_q);
              buzzer_q <= ~phase_q & ~bus.mute;
            end else begin
              half_q   <= half_q - HALF_W'(1);
              buzzer_q <= phase_q & ~bus.mute;
            end
            if (dur_q == {DUR_W{1'b0}}) begin
              state_q  <= ST_GAP;
              dur_q    <= DUR_W'(GAP_CYCLES - 1);
              buzzer_q <= 1'b0;
            end else begin
              dur_q <= dur_q - DUR_W'(1);
            end
          end
          ST_GAP: begin
            buzzer_q <= 1'b0;
            if (dur_q == {DUR_W{1'b0}}) begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              tone_id_q <= 2'd0;
            end else begin
              dur_q <= dur_q - DUR_W'(1);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            buzzer_q  <= 1'b0;
            tone_id_q <= 2'd0;
          end
        endcase
`ifdef BOUNCE_SOUND_QUEUE_EN
        if ((state_q != ST_IDLE) && take_s) begin
          pend_q <= bus.bounce;
        end else begin
          pend_q <= pend_q;
        end
`endif
      end
    end
  end

  assign bus.buzzer  = buzzer_q;
  assign bus.busy    = busy_q;
  assign bus.tone_id = tone_id_q;

endmodule

// File: tb/tb_bounce_sound.sv
// Directed bench for bounce_sound with small timing parameters; expectations
// follow BOUNCE_SOUND_QUEUE_EN when it is defined.
module tb_bounce_sound;

  localparam int WH = 4;
  localparam int PH = 2;
  localparam int SH = 8;
  localparam int TC = 40;
  localparam int GC = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bounce_sound_if bus ();

  bounce_sound #(
    .WALL_HALF  (WH),
    .PADDLE_HALF(PH),
    .SCORE_HALF (SH),
    .TONE_CYCLES(TC),
    .GAP_CYCLES (GC)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_buz"}, 32'(bus.buzzer), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_id"}, 32'(bus.tone_id), 32'd0);
  endtask

  // Called just after the tone's first edge; leaves us just after the gap starts.
  task automatic tone_phase(input logic [1:0] code, input int half, input int len,
                            input logic muted, input logic hold,
                            input int k1, input logic [1:0] c1,
                            input int k2, input logic [1:0] c2);
    for (int k = 0; k < len; k++) begin
      chk("tone_buz", 32'(bus.buzzer), muted ? 32'd0 : 32'((((k / half) % 2) == 0)));
      chk("tone_busy", 32'(bus.busy), 32'd1);
      chk("tone_id", 32'(bus.tone_id), 32'(code));
      if (k == k1) bus.bounce = c1;
      else if (k == k2) bus.bounce = c2;
      else if (!hold) bus.bounce = 2'd0;
      tick();
    end
  endtask

  task automatic gap_phase(input logic [1:0] code, input int kin, input logic [1:0] cin);
    for (int k = 0; k < GC; k++) begin
      chk("gap_buz", 32'(bus.buzzer), 32'd0);
      chk("gap_busy", 32'(bus.busy), 32'd1);
      chk("gap_id", 32'(bus.tone_id), 32'(code));
      if (k == kin) bus.bounce = cin;
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.mute   = 1'b0;
    bus.bounce = 2'd0;

    // Reset state
    tick(); tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick(); tick();
    chk_idle("post_reset");

    // Wall held for 100 cycles: exactly one tone
    bus.bounce = 2'd1;
    tick();
    tone_phase(2'd1, WH, TC, 1'b0, 1'b1, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd1, -1, 2'd0);
    for (int i = 0; i < 49; i++) begin
      chk_idle("wall_hold");
      tick();
    end
    bus.bounce = 2'd0;
    tick();

    // Score tone: double length, period 16
    bus.bounce = 2'd3;
    tick();
    tone_phase(2'd3, SH, 2 * TC, 1'b0, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd3, -1, 2'd0);
    chk_idle("score_end");

    // Wall then paddle five cycles later
    bus.bounce = 2'd1;
    tick();
    tone_phase(2'd1, WH, TC, 1'b0, 1'b0, 5, 2'd2, -1, 2'd0);
    gap_phase(2'd1, -1, 2'd0);
`ifdef BOUNCE_SOUND_QUEUE_EN
    tone_phase(2'd2, PH, TC, 1'b0, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd2, -1, 2'd0);
`endif
    chk_idle("queue_end");

    // Pending paddle then lower-priority wall: paddle kept
    bus.bounce = 2'd1;
    tick();
    tone_phase(2'd1, WH, TC, 1'b0, 1'b0, 5, 2'd2, 10, 2'd1);
    gap_phase(2'd1, -1, 2'd0);
`ifdef BOUNCE_SOUND_QUEUE_EN
    tone_phase(2'd2, PH, TC, 1'b0, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd2, -1, 2'd0);
`endif
    chk_idle("prio_a_end");

    // Pending wall then score: score overwrites
    bus.bounce = 2'd2;
    tick();
    tone_phase(2'd2, PH, TC, 1'b0, 1'b0, 5, 2'd1, 10, 2'd3);
    gap_phase(2'd2, -1, 2'd0);
`ifdef BOUNCE_SOUND_QUEUE_EN
    tone_phase(2'd3, SH, 2 * TC, 1'b0, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd3, -1, 2'd0);
`endif
    chk_idle("prio_b_end");

    // Event landing on the final gap cycle
    bus.bounce = 2'd2;
    tick();
    tone_phase(2'd2, PH, TC, 1'b0, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd2, GC - 1, 2'd1);
`ifdef BOUNCE_SOUND_QUEUE_EN
    tone_phase(2'd1, WH, TC, 1'b0, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd1, -1, 2'd0);
`endif
    chk_idle("gap_edge_end");
    bus.bounce = 2'd0;
    tick();

    // Muted paddle: silent buzzer, same timing
    bus.mute   = 1'b1;
    bus.bounce = 2'd2;
    tick();
    tone_phase(2'd2, PH, TC, 1'b1, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd2, -1, 2'd0);
    chk_idle("mute_end");
    bus.mute = 1'b0;
    tick();

    // Reset at cycle 20 of a tone with a score pending
    bus.bounce = 2'd1;
    tick();
    tone_phase(2'd1, WH, 20, 1'b0, 1'b0, 5, 2'd3, -1, 2'd0);
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk_idle("after_reset");
    end

    // Non-zero level present at reset release
    rst_n      = 1'b0;
    bus.bounce = 2'd2;
    tick();
    rst_n = 1'b1;
    tick();
    tone_phase(2'd2, PH, TC, 1'b0, 1'b0, -1, 2'd0, -1, 2'd0);
    gap_phase(2'd2, -1, 2'd0);
    chk_idle("release_event_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
